pipelined_addsub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor that generalises the team's fixed 4-bit full adder.
- Operand width and pipeline depth are configurable; the carry chain is split into STAGES equal segments, one segment per register stage.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake on both sides.
- Sits between operand-producing datapath logic and a consumer that may stall.

---
 rtl/pipelined_addsub.sv | 157 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//
// Parametrised, pipelined ripple-carry adder/subtractor. The carry chain is cut
// into STAGES equal segments of SEG = WIDTH/STAGES bits, with one segment per
// register stage. Stage k computes result bits [k*SEG +: SEG] from the carry
// registered by stage k-1. The operands that have not yet been consumed travel
// down the pipe with the beat. Low sum slices that are already computed are
// carried forward unchanged. The last stage register drives the outputs
// directly.
//
// Subtraction uses b XOR {WIDTH{sub}} and cin XOR sub. This means cout=1 in
// subtract mode signals "no borrow".
//
// Flow control: one global advance enable, en = ~out_valid | out_ready. When
// en=0 the whole pipe freezes, bubbles included.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset, empties the pipe
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (equals the advance enable)
//   a, b       operands, WIDTH bits
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0 = add, 1 = subtract
//   out_valid  result present
//   out_ready  consumer accepts the result
//   sum        result, WIDTH bits (modulo 2^WIDTH)
//   cout       carry out of bit WIDTH-1
//   overflow   two's-complement overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int SEG = WIDTH / STAGES;

    // Bit-level ripple over one segment.
    // Returns {carry into top bit, carry out, segment sum}.
    function automatic logic [SEG+1:0] ripple_seg(
        input logic [SEG-1:0] x_v,
        input logic [SEG-1:0] y_v,
        input logic           c_in_v
    );
        logic [SEG-1:0] s_v;
        logic           c_v;
        logic           c_top_v;
        s_v     = {SEG{1'b0}};
        c_v     = c_in_v;
        c_top_v = c_in_v;
        for (int i = 0; i < SEG; i++) begin
            s_v[i]  = x_v[i] ^ y_v[i] ^ c_v;
            c_top_v = c_v;
            c_v     = (x_v[i] & y_v[i]) | (c_v & (x_v[i] ^ y_v[i]));
        end
        return {c_top_v, c_v, s_v};
    endfunction

    // Pipeline registers, one entry per stage.
    logic [STAGES-1:0]            valid_r;
    logic [STAGES-1:0]            carry_r;
    logic [STAGES-1:0][WIDTH-1:0] opa_r;
    logic [STAGES-1:0][WIDTH-1:0] opb_r;
    logic [STAGES-1:0][WIDTH-1:0] sum_r;
    logic                         ovf_r;

    // Chains: index k is the input of stage k. Index 0 is the incoming beat
    // (with b and the carry already conditioned for subtract). Index k>0 is
    // the register of stage k-1.
    logic [STAGES:0]              valid_chain_s;
    logic [STAGES:0]              carry_chain_s;
    logic [STAGES:0][WIDTH-1:0]   opa_chain_s;
    logic [STAGES:0][WIDTH-1:0]   opb_chain_s;
    logic [STAGES:0][WIDTH-1:0]   sum_chain_s;

    logic [STAGES-1:0]            nxt_valid_s;
    logic [STAGES-1:0]            nxt_carry_s;
    logic [STAGES-1:0][WIDTH-1:0] nxt_opa_s;
    logic [STAGES-1:0][WIDTH-1:0] nxt_opb_s;
    logic [STAGES-1:0][WIDTH-1:0] nxt_sum_s;
    logic                         nxt_ovf_s;
    logic [SEG+1:0]               rip_s;
    logic                         en_s;

    assign en_s     = ~valid_r[STAGES-1] | out_ready;
    assign in_ready = en_s;

    assign valid_chain_s = {valid_r, in_valid};
    assign carry_chain_s = {carry_r, cin ^ sub};
    assign opa_chain_s   = {opa_r, a};
    assign opb_chain_s   = {opb_r, b ^ {WIDTH{sub}}};
    assign sum_chain_s   = {sum_r, {WIDTH{1'b0}}};

    // Per-stage segment arithmetic and next-state for every stage register.
    always_comb begin
        nxt_valid_s = {STAGES{1'b0}};
        nxt_carry_s = {STAGES{1'b0}};
        nxt_opa_s   = {(STAGES*WIDTH){1'b0}};
        nxt_opb_s   = {(STAGES*WIDTH){1'b0}};
        nxt_sum_s   = {(STAGES*WIDTH){1'b0}};
        nxt_ovf_s   = 1'b0;
        rip_s       = {(SEG+2){1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            rip_s = ripple_seg(opa_chain_s[k][k*SEG +: SEG],
                               opb_chain_s[k][k*SEG +: SEG],
                               carry_chain_s[k]);
            nxt_valid_s[k]              = valid_chain_s[k];
            nxt_opa_s[k]                = opa_chain_s[k];
            nxt_opb_s[k]                = opb_chain_s[k];
            nxt_sum_s[k]                = sum_chain_s[k];
            nxt_sum_s[k][k*SEG +: SEG]  = rip_s[SEG-1:0];
            nxt_carry_s[k]              = rip_s[SEG];
            // The final iteration covers the MSB, so its value is what is kept.
            nxt_ovf_s                   = rip_s[SEG+1] ^ rip_s[SEG];
        end
    end

    // Stage registers: the whole pipe shifts on en and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            opa_r   <= {(STAGES*WIDTH){1'b0}};
            opb_r   <= {(STAGES*WIDTH){1'b0}};
            sum_r   <= {(STAGES*WIDTH){1'b0}};
            ovf_r   <= 1'b0;
        end else if (en_s) begin
            valid_r <= nxt_valid_s;
            carry_r <= nxt_carry_s;
            opa_r   <= nxt_opa_s;
            opb_r   <= nxt_opb_s;
            sum_r   <= nxt_sum_s;
            ovf_r   <= nxt_ovf_s;
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = carry_r[STAGES-1];
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Scoreboard bench for pipelined_addsub (WIDTH=16, STAGES=4). Each accepted
// beat pushes its expected {overflow, cout, sum} onto a queue. The queue head
// is compared whenever a result is presented, and it is popped when the result
// is consumed. A small valid-bit model of the pipe predicts in_ready and
// out_valid on every cycle.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

    localparam int W  = 16;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int           checks   = 0;
    int           failures = 0;
    logic [W+1:0] sb_q[$];
    logic [ST-1:0] mvalid;

    pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, cout, sum}. Overflow is derived from operand and
    // result signs.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                               input logic rc, input logic rs);
        logic [W-1:0] beff;
        logic [W:0]   full;
        logic         ovf;
        beff = rs ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, beff} + {{W{1'b0}}, rc ^ rs};
        ovf  = (ra[W-1] == beff[W-1]) && (full[W-1] != ra[W-1]);
        return {ovf, full[W], full[W-1:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check at negedge, update model, advance to posedge+1.
    task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tc, input logic ts, input logic tr,
                        input logic [W+1:0] exp_v, output logic acc);
        logic men;
        in_valid  = v;
        a         = ta;
        b         = tbv;
        cin       = tc;
        sub       = ts;
        out_ready = tr;
        @(negedge clk);
        men = ~mvalid[ST-1] | tr;
        check_eq("in_ready", 32'(in_ready), 32'(men));
        check_eq("out_valid", 32'(out_valid), 32'(mvalid[ST-1]));
        if (mvalid[ST-1] && sb_q.size() > 0) begin
            check_eq("result", 32'({overflow, cout, sum}), 32'(sb_q[0]));
            if (tr) void'(sb_q.pop_front());
        end
        acc = v & men;
        if (acc) sb_q.push_back(exp_v);
        if (men) mvalid = {mvalid[ST-2:0], v};
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++)
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 18'h00000, acc);
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc;
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vc [6];
        logic         vs [6];
        int           sent;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        mvalid = {ST{1'b0}};
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: carry out of full width, latency through 4 stages.
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 18'h10000, acc);
        drain();

        // Tests 2 and 3: overflow, carry-in, subtract with and without borrow.
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 18'h28000, acc);
        step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 18'h05556, acc);
        step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 18'h0FFFE, acc);
        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 18'h37FFF, acc);
        drain();

        // Test 4: six beats with the consumer stalled for cycles 3..7.
        for (int i = 0; i < 6; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            vc[i] = 1'($urandom);
            vs[i] = 1'($urandom);
        end
        sent = 0;
        for (int cyc = 0; cyc < 40 && sent < 6; cyc++) begin
            step(1'b1, va[sent], vb[sent], vc[sent], vs[sent], !(cyc >= 3 && cyc < 8),
                 ref_model(va[sent], vb[sent], vc[sent], vs[sent]), acc);
            if (acc) sent++;
        end
        check_eq("bp_sent", 32'(sent), 32'd6);
        drain();

        // Test 5: back-to-back random beats with simultaneous accept and consume.
        for (int i = 0; i < 32; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            step(1'b1, ra, rb, rc, rs, 1'b1, ref_model(ra, rb, rc, rs), acc);
        end
        drain();

        // Test 6: asynchronous reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            step(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, ref_model(ra, rb, 1'b0, 1'b0), acc);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_sum", 32'(sum), 32'd0);
        mvalid = {ST{1'b0}};
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        step(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1, 18'h01000, acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
